dcache_store_buffer: RTL

//  Responder side of the SQ->dcache store interface. Accepts up to NUM_SQ_DCACHE committed stores/cycle,

---
 rtl/dcache_store_buffer_pkg.sv | 27 ++
 rtl/dcache_store_buffer_if.sv | 25 ++
 rtl/dcache_store_buffer_store_align.sv | 12 +
 rtl/dcache_store_buffer.sv | 103 ++++++++++
 4 files changed

// File: rtl/dcache_store_buffer_pkg.sv
// dcache_store_buffer_pkg: shared types, lane defaults and merge helper for the dcache store buffer (optional macro DCACHE_STORE_BUFFER_MERGE_EN)
`ifndef NUM_SQ_DCACHE
`define NUM_SQ_DCACHE 2
`endif
package dcache_store_buffer_pkg;
  localparam int SQ_LANES = `NUM_SQ_DCACHE;
  localparam int LD_PORTS = 2;
  typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD, MEM_DOUBLE} mem_size_e;
  typedef enum logic [1:0] {WB_IDLE, WB_REQ, WB_WAIT} wb_state_e;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  sign_size;
    logic [31:0] data;
  } sq_dcache_packet_t;
  typedef struct packed {
    logic        valid;
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } wb_entry_t;
  function automatic wb_entry_t wb_merge(input wb_entry_t e, input logic [3:0] m, input logic [31:0] d);
    for (int b = 0; b < 4; b++) if (m[b]) e.data[8*b +: 8] = d[8*b +: 8];
    e.mask = e.mask | m;
    return e;
  endfunction
endpackage

// File: rtl/dcache_store_buffer_if.sv
// dcache_store_buffer_if: SQ store lanes, memory write channel and LQ conflict probe of the store buffer
interface dcache_store_buffer_if import dcache_store_buffer_pkg::*; #(
  parameter int N_SQ = SQ_LANES,
  parameter int N_LD = LD_PORTS
) ();
  sq_dcache_packet_t [N_SQ-1:0] sq_dcache_packet;
  logic [N_SQ-1:0] dcache_accept;
  logic mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0] mem_req_mask;
  logic mem_req_ready;
  logic mem_resp_valid;
  logic [N_LD-1:0][31:0] lq_addr;
  logic [N_LD-1:0] wb_hit;
  logic wb_empty;
  modport master (
    output sq_dcache_packet, mem_req_ready, mem_resp_valid, lq_addr,
    input dcache_accept, mem_req_valid, mem_req_addr, mem_req_data, mem_req_mask, wb_hit, wb_empty
  );
  modport slave (
    input sq_dcache_packet, mem_req_ready, mem_resp_valid, lq_addr,
    output dcache_accept, mem_req_valid, mem_req_addr, mem_req_data, mem_req_mask, wb_hit, wb_empty
  );
endinterface

// File: rtl/dcache_store_buffer_store_align.sv
// dcache_store_buffer_store_align: places a store's bytes in their word lanes and builds the byte mask
module dcache_store_buffer_store_align import dcache_store_buffer_pkg::*; (
  input  logic [1:0]  offset,
  input  mem_size_e   size,
  input  logic [31:0] data,
  output logic [3:0]  mask,
  output logic [31:0] lane_data
);
  assign mask = size == MEM_BYTE ? 4'b0001 << offset : size == MEM_HALF ? 4'b0011 << {offset[1], 1'b0} : 4'hf;
  assign lane_data = size == MEM_BYTE ? {24'b0, data[7:0]} << {offset, 3'b0}
                   : size == MEM_HALF ? {16'b0, data[15:0]} << {offset[1], 4'b0} : data;
endmodule

// File: rtl/dcache_store_buffer.sv
// dcache_store_buffer: aligns committed SQ stores into a WB_LEN-entry FIFO drained in order to memory; define DCACHE_STORE_BUFFER_MERGE_EN to merge stores into pending words
module dcache_store_buffer import dcache_store_buffer_pkg::*; #(
  parameter int WB_LEN = 4,
  parameter int NUM_SQ_DCACHE = SQ_LANES,
  parameter int NUM_FU_LOAD = LD_PORTS
) (
  input logic clock,
  input logic reset,
  dcache_store_buffer_if.slave sb
);
  localparam int IW = $clog2(WB_LEN);
  localparam int CW = $clog2(WB_LEN + 1);
  typedef logic [IW-1:0] wb_idx_t;
  wb_state_e state_q, state_d;
  wb_entry_t [WB_LEN-1:0] entries_q, entries_d;
  wb_idx_t head_q, tail_q, slot, tgt;
  logic [CW-1:0] count_q, free, n_new;
  logic [NUM_SQ_DCACHE-1:0][3:0] mask;
  logic [NUM_SQ_DCACHE-1:0][31:0] data;
  logic [NUM_SQ_DCACHE-1:0] acc;
  logic pop, ok, mrg, unused_bits;
  for (genvar l = 0; l < NUM_SQ_DCACHE; l++) begin : g_align
    dcache_store_buffer_store_align u_align (
      .offset    (sb.sq_dcache_packet[l].addr[1:0]),
      .size      (mem_size_e'(sb.sq_dcache_packet[l].sign_size[1:0])),
      .data      (sb.sq_dcache_packet[l].data),
      .mask      (mask[l]),
      .lane_data (data[l])
    );
  end
  assign free = CW'(WB_LEN) - count_q;
  assign pop = state_q == WB_WAIT && sb.mem_resp_valid;
  // Prefix acceptance and FIFO update; a popped slot only becomes free next cycle
  always_comb begin
    entries_d = entries_q;
    if (pop) entries_d[head_q] = '0;
    acc = '0;
    n_new = '0;
    ok = 1'b1;
    mrg = 1'b0;
    tgt = '0;
    slot = '0;
    for (int i = 0; i < NUM_SQ_DCACHE; i++) begin
      mrg = 1'b0;
      tgt = '0;
`ifdef DCACHE_STORE_BUFFER_MERGE_EN
      for (int k = 0; k < WB_LEN; k++)
        if (!mrg && entries_d[k].valid && entries_d[k].addr == sb.sq_dcache_packet[i].addr[31:2] &&
            !(wb_idx_t'(k) == head_q && state_q != WB_IDLE)) begin
          mrg = 1'b1;
          tgt = wb_idx_t'(k);
        end
`endif
      acc[i] = ok && reset && sb.sq_dcache_packet[i].valid && (mrg || n_new < free);
      ok = acc[i];
      slot = mrg ? tgt : tail_q + wb_idx_t'(n_new);
      if (acc[i]) entries_d[slot] = mrg ? wb_merge(entries_d[slot], mask[i], data[i])
                                        : '{1'b1, sb.sq_dcache_packet[i].addr[31:2], mask[i], data[i]};
      if (acc[i] && !mrg) n_new = n_new + CW'(1);
    end
  end
  // Drain sequencer: present head, wait for handshake, then for write completion
  always_comb begin
    state_d = state_q == WB_IDLE ? (count_q != '0 ? WB_REQ : WB_IDLE)
            : state_q == WB_REQ ? (sb.mem_req_ready ? WB_WAIT : WB_REQ)
            : (sb.mem_resp_valid ? WB_IDLE : WB_WAIT);
  end
  // State, pointers and entries
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= WB_IDLE;
      count_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      entries_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_q + n_new - CW'(pop);
      head_q <= head_q + wb_idx_t'(pop);
      tail_q <= tail_q + wb_idx_t'(n_new);
      entries_q <= entries_d;
    end
  end
  // Word-granular conflict check of load addresses against every pending entry
  always_comb begin
    sb.wb_hit = '0;
    for (int i = 0; i < NUM_FU_LOAD; i++)
      for (int k = 0; k < WB_LEN; k++)
        if (entries_q[k].valid && entries_q[k].addr == sb.lq_addr[i][31:2]) sb.wb_hit[i] = 1'b1;
  end
  // Sign flag and load byte offsets do not matter at word granularity
  always_comb begin
    unused_bits = 1'b0;
    for (int i = 0; i < NUM_SQ_DCACHE; i++) unused_bits = unused_bits ^ sb.sq_dcache_packet[i].sign_size[2];
    for (int i = 0; i < NUM_FU_LOAD; i++) unused_bits = unused_bits ^ (^sb.lq_addr[i][1:0]);
  end
  assign sb.dcache_accept = acc;
  assign sb.mem_req_valid = state_q == WB_REQ;
  assign sb.mem_req_addr = sb.mem_req_valid ? {entries_q[head_q].addr, 2'b00} : '0;
  assign sb.mem_req_data = sb.mem_req_valid ? entries_q[head_q].data : '0;
  assign sb.mem_req_mask = sb.mem_req_valid ? entries_q[head_q].mask : '0;
  assign sb.wb_empty = count_q == '0 && state_q == WB_IDLE;
endmodule
